// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch stage between ProgramCounter and decode.
// Ports:
//   CLK, RESET                      clock, synchronous active-high reset
//   PC / WE_PC, PC_IN               current PC in; PC write-back (PC+PC_STEP or redirect target)
//   REDIRECT, REDIRECT_PC           branch/jump taken: squash everything and refetch from target
//   IMEM_REQ_VALID/READY, IMEM_ADDR request channel to instruction memory
//   IMEM_RSP_VALID, IMEM_RDATA      in-order responses, at least one cycle after accept
//   INSTR_VALID/READY, INSTR,
//   INSTR_PC, INSTR_FAULT           decode handshake and payload
// Optional: define FETCH_MISALIGN_EN to turn misaligned PCs into a single faulting NOP
// that halts fetch until the next redirect; otherwise INSTR_FAULT is tied low.
module fetch_unit #(
  parameter int FIFO_DEPTH = 2,
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] PC,
  output logic        WE_PC,
  output logic [31:0] PC_IN,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_REQ_VALID,
  input  logic        IMEM_REQ_READY,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_RSP_VALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY,
  output logic [31:0] INSTR,
  output logic [31:0] INSTR_PC,
  output logic        INSTR_FAULT
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = 8;
  localparam logic [31:0] NOP = 32'h00000013;

  logic [31:0] q_pc [FIFO_DEPTH];
  logic [31:0] q_instr [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] q_filled;
  logic [AW-1:0] head, fill_ptr, tail;
  logic [CW-1:0] count, pend;
  logic [DW-1:0] drop_cnt;
  logic room, accept, fault_alloc, alloc, pop, fill, drop;

  // Credit uses the registered count, so a pop this cycle does not free a slot until next cycle.
  assign room = !RESET && !REDIRECT && count < CW'(FIFO_DEPTH);

`ifdef FETCH_MISALIGN_EN
  logic halt;
  logic [FIFO_DEPTH-1:0] q_fault;
  assign fault_alloc = room && !halt && PC[1:0] != 2'b00;
  assign IMEM_REQ_VALID = room && !halt && PC[1:0] == 2'b00;
  assign INSTR_FAULT = INSTR_VALID && q_fault[head];
  always_ff @(posedge CLK) begin
    if (RESET || REDIRECT) halt <= 1'b0;
    else if (fault_alloc) halt <= 1'b1;
    if (alloc) q_fault[tail] <= fault_alloc;
  end
`else
  assign fault_alloc = 1'b0;
  assign IMEM_REQ_VALID = room;
  assign INSTR_FAULT = 1'b0;
`endif

  assign accept = IMEM_REQ_VALID && IMEM_REQ_READY;
  assign alloc = accept || fault_alloc;
  assign INSTR_VALID = count != '0 && q_filled[head];
  assign pop = INSTR_VALID && INSTR_READY;
  assign drop = IMEM_RSP_VALID && drop_cnt != '0;
  assign fill = IMEM_RSP_VALID && drop_cnt == '0;
  assign WE_PC = !RESET && (REDIRECT || accept);
  assign PC_IN = REDIRECT ? REDIRECT_PC : accept ? PC + PC_STEP : PC;
  assign IMEM_ADDR = PC;
  assign INSTR = q_instr[head];
  assign INSTR_PC = q_pc[head];

  // Payload storage needs no reset: validity is carried by count and q_filled.
  always_ff @(posedge CLK) begin
    if (alloc) begin
      q_pc[tail] <= PC;
      q_instr[tail] <= NOP;
    end
    if (fill) q_instr[fill_ptr] <= IMEM_RDATA;
  end

  // pend counts live entries still waiting for memory; on a redirect they become
  // responses to discard, minus the one (live or already doomed) arriving right now.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      head <= '0;
      fill_ptr <= '0;
      tail <= '0;
      count <= '0;
      pend <= '0;
      drop_cnt <= '0;
      q_filled <= '0;
    end else if (REDIRECT) begin
      head <= '0;
      fill_ptr <= '0;
      tail <= '0;
      count <= '0;
      pend <= '0;
      drop_cnt <= drop_cnt + DW'(pend) - DW'(IMEM_RSP_VALID);
    end else begin
      if (alloc) begin
        q_filled[tail] <= fault_alloc;
        tail <= tail + AW'(1);
      end
      if (fill) begin
        q_filled[fill_ptr] <= 1'b1;
        fill_ptr <= fill_ptr + AW'(1);
      end
      if (drop) drop_cnt <= drop_cnt - DW'(1);
      if (pop) head <= head + AW'(1);
      count <= count + CW'(alloc) - CW'(pop);
      pend <= pend + CW'(accept) - CW'(fill);
    end
  end

  a_rsp_outstanding: assert property (@(posedge CLK) disable iff (RESET)
    IMEM_RSP_VALID |-> (pend != '0 || drop_cnt != '0));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a ProgramCounter register and an in-order memory model.
module tb_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, redirect, req_ready, rsp_valid, instr_ready;
  logic [31:0] pc, redirect_pc, rdata;
  logic we_pc, req_valid, instr_valid, instr_fault;
  logic [31:0] pc_in, imem_addr, instr, instr_pc;

  fetch_unit dut (
    .CLK(clk), .RESET(rst), .PC(pc), .WE_PC(we_pc), .PC_IN(pc_in),
    .REDIRECT(redirect), .REDIRECT_PC(redirect_pc),
    .IMEM_REQ_VALID(req_valid), .IMEM_REQ_READY(req_ready), .IMEM_ADDR(imem_addr),
    .IMEM_RSP_VALID(rsp_valid), .IMEM_RDATA(rdata),
    .INSTR_VALID(instr_valid), .INSTR_READY(instr_ready), .INSTR(instr),
    .INSTR_PC(instr_pc), .INSTR_FAULT(instr_fault)
  );

  typedef struct packed {logic [31:0] pc; logic [31:0] instr; logic fault;} exp_t;
  typedef struct {logic [31:0] addr; int due;} mreq_t;
  exp_t exp_q[$];
  mreq_t mem_q[$];
  int n_checks = 0, n_fail = 0, cyc = 0, lat = 1, n_acc = 0, n_pop = 0;
  bit watch = 1'b0;
  logic [31:0] first_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    logic acc, pp, we, rs;
    logic [31:0] pin, addr;
    exp_t e;
    mreq_t m;
    @(negedge clk);
    acc = req_valid && req_ready;
    pp = instr_valid && instr_ready;
    if (rst) begin
      check("rst_req_valid", req_valid, 0);
      check("rst_we_pc", we_pc, 0);
    end else if (pc[1:0] == 2'b00) begin
      check("req_valid", req_valid, !redirect && exp_q.size() < DEPTH);
      check("we_pc", we_pc, redirect || acc);
      check("pc_in", pc_in, redirect ? redirect_pc : acc ? pc + 32'd4 : pc);
      if (req_valid) check("imem_addr", imem_addr, pc);
    end
    if (pp && !rst) begin
      if (exp_q.size() == 0) check("pop_unexpected", instr_pc, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        check("instr_pc", instr_pc, e.pc);
        check("instr", instr, e.instr);
        check("instr_fault", instr_fault, e.fault);
      end
      if (watch) begin
        first_pc = instr_pc;
        watch = 1'b0;
      end
      n_pop++;
    end
    if (acc) begin
      exp_q.push_back('{pc, mem_word(pc), 1'b0});
      n_acc++;
    end
    if (rst || redirect) exp_q.delete();
    we = we_pc;
    pin = pc_in;
    rs = rst;
    addr = pc;
    @(posedge clk);
    cyc++;
    #1;
    if (rs) mem_q.delete();
    if (we) pc = pin;
    if (acc) mem_q.push_back('{addr, cyc + lat - 1});
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      rsp_valid = 1'b1;
      rdata = mem_word(m.addr);
    end else begin
      rsp_valid = 1'b0;
      rdata = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    req_ready = 1'b0;
    instr_ready = 1'b1;
    repeat (10) tick();
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0, a0;
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'hDEAD_0000;
    req_ready = 1'b1; rsp_valid = 1'b0; rdata = '0; instr_ready = 1'b1; pc = '0;
    repeat (2) tick();
    rst = 1'b0; redirect = 1'b0;
    check("reset_instr_valid", instr_valid, 0);
    check("reset_instr_fault", instr_fault, 0);
    check("reset_drop_cnt", dut.drop_cnt, 0);

    pc = 32'h0040_0000; lat = 1; req_ready = 1'b1; instr_ready = 1'b1;
    p0 = n_pop; n_acc = 0;
    repeat (30) tick();
    check("t1_throughput", n_pop - p0 >= 18, 1);
    check("t1_pc", pc, 32'h0040_0000 + 32'(4 * n_acc));
    drain("t1_drain");

    do_reset();
    pc = 32'h0040_0000; req_ready = 1'b1; instr_ready = 1'b0; n_acc = 0;
    repeat (5) tick();
    check("t2_issued", n_acc, 2);
    check("t2_stalled", req_valid, 0);
    p0 = n_pop;
    instr_ready = 1'b1;
    repeat (10) tick();
    drain("t2_drain");
    check("t2_nolossdup", n_pop - p0, n_acc);

    do_reset();
    lat = 3; pc = 32'h0040_0000; req_ready = 1'b1; instr_ready = 1'b1; n_acc = 0;
    repeat (2) tick();
    check("t3_inflight", n_acc, 2);
    redirect = 1'b1; redirect_pc = 32'h0040_0100;
    #1;
    check("t3_we_pc", we_pc, 1);
    check("t3_pc_in", pc_in, 32'h0040_0100);
    check("t3_req_valid", req_valid, 0);
    tick();
    redirect = 1'b0;
    check("t3_drop_cnt", dut.drop_cnt, 2);
    check("t3_pc", pc, 32'h0040_0100);
    watch = 1'b1;
    repeat (20) tick();
    check("t3_first_pc", first_pc, 32'h0040_0100);
    check("t3_drop_done", dut.drop_cnt, 0);
    drain("t3_drain");

    do_reset();
    lat = 1; pc = 32'h0040_0000; req_ready = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 10 && pc != 32'h0040_0008; i++) tick();
    check("t4_reach", pc, 32'h0040_0008);
    req_ready = 1'b0;
    repeat (3) begin
      #1;
      check("t4_we_pc", we_pc, 0);
      check("t4_addr", imem_addr, 32'h0040_0008);
      tick();
    end
    check("t4_pc_held", pc, 32'h0040_0008);
    req_ready = 1'b1;
    repeat (10) tick();
    drain("t4_drain");

    do_reset();
    pc = 32'h0040_0000; req_ready = 1'b1; instr_ready = 1'b0;
    repeat (6) tick();
    check("t5_full", req_valid, 0);
    rst = 1'b1;
    tick();
    check("t5_instr_valid", instr_valid, 0);
    check("t5_req_valid", req_valid, 0);
    check("t5_drop_cnt", dut.drop_cnt, 0);
    rst = 1'b0;

`ifdef FETCH_MISALIGN_EN
    do_reset();
    pc = 32'h0040_0000; lat = 1; req_ready = 1'b1; instr_ready = 1'b1;
    repeat (3) tick();
    redirect = 1'b1; redirect_pc = 32'h0040_0102;
    tick();
    redirect = 1'b0;
    exp_q.push_back('{32'h0040_0102, NOP, 1'b1});
    a0 = n_acc; p0 = n_pop;
    repeat (10) tick();
    check("ma_no_req", n_acc - a0, 0);
    check("ma_pops", n_pop - p0, 1);
    check("ma_pc_held", pc, 32'h0040_0102);
    redirect = 1'b1; redirect_pc = 32'h0040_0200;
    tick();
    redirect = 1'b0;
    a0 = n_acc;
    repeat (10) tick();
    check("ma_resume", n_acc - a0 > 0, 1);
    drain("ma_drain");
`else
    a0 = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
